// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around mem_port_arbiter.
// master = the arbiter's view; slave = the requesters/memory environment.
interface mem_port_arbiter_if #(
    parameter int D_WIDTH = 32
);
    logic               if_req;
    logic [D_WIDTH-1:0] if_addr;
    logic [D_WIDTH-1:0] if_rdata;
    logic               if_valid;
    logic               if_stall;

    logic               dm_req;
    logic               dm_we;
    logic [D_WIDTH-1:0] dm_addr;
    logic [D_WIDTH-1:0] dm_wdata;
    logic [3:0]         dm_be;
    logic [D_WIDTH-1:0] dm_rdata;
    logic               dm_valid;
    logic               dm_stall;

    logic               mem_req;
    logic               mem_we;
    logic [D_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [3:0]         mem_be;
    logic [D_WIDTH-1:0] mem_rdata;
    logic               mem_ready;

    logic [1:0]         grant;
    logic               bus_err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata, mem_ready,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, grant, bus_err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata, mem_ready,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, grant, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory (data wins ties, then alternates).
// Define ARB_TIMEOUT_EN to compile in the mem_ready watchdog that aborts a stuck access and pulses bus_err.
module mem_port_arbiter #(
    parameter int D_WIDTH = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    // Encoding doubles as the grant code.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IF_ACC = 2'b01,
        DM_ACC = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [D_WIDTH-1:0] addr_r;
    logic [D_WIDTH-1:0] addr_s;
    logic [D_WIDTH-1:0] wdata_r;
    logic [D_WIDTH-1:0] wdata_s;
    logic               we_r;
    logic               we_s;
    logic [3:0]         be_r;
    logic [3:0]         be_s;
    logic               active_s;
    logic               done_s;
    logic               abort_s;
    logic               take_dm_s;
    logic               take_if_s;

    assign active_s = (state_r != IDLE);
    assign done_s   = active_s && bus.mem_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] wait_r;

    // Fires on the TIMEOUT-th consecutive stalled cycle, while the owner's grant is still shown.
    assign abort_s = active_s && !bus.mem_ready && (wait_r == CNT_W'(TIMEOUT - 1));

    // Consecutive stalled-access counter, restarted on any state change
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_r <= {CNT_W{1'b0}};
        end else if ((state_s != state_r) || !active_s) begin
            wait_r <= {CNT_W{1'b0}};
        end else if (!bus.mem_ready) begin
            wait_r <= wait_r + CNT_W'(1);
        end else begin
            wait_r <= wait_r;
        end
    end
`else
    assign abort_s = 1'b0;
`endif

    // Next-state selection and capture of the new owner's request fields
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        we_s      = we_r;
        wdata_s   = wdata_r;
        be_s      = be_r;
        take_dm_s = 1'b0;
        take_if_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.dm_req) begin
                    take_dm_s = 1'b1;
                end else begin
                    take_if_s = bus.if_req;
                end
            end
            IF_ACC: begin
                // The finishing requester's own req is ignored here so the other side gets a turn.
                if (done_s) begin
                    take_dm_s = bus.dm_req;
                    state_s   = IDLE;
                end else if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = IF_ACC;
                end
            end
            DM_ACC: begin
                if (done_s) begin
                    take_if_s = bus.if_req;
                    state_s   = IDLE;
                end else if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DM_ACC;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (take_dm_s) begin
            state_s = DM_ACC;
            addr_s  = bus.dm_addr;
            we_s    = bus.dm_we;
            wdata_s = bus.dm_wdata;
            be_s    = bus.dm_be;
        end else if (take_if_s) begin
            state_s = IF_ACC;
            addr_s  = bus.if_addr;
            we_s    = 1'b0;
            wdata_s = {D_WIDTH{1'b0}};
            be_s    = 4'b1111;
        end else begin
            addr_s  = addr_r;
        end
    end

    // State and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= {D_WIDTH{1'b0}};
            we_r    <= 1'b0;
            wdata_r <= {D_WIDTH{1'b0}};
            be_r    <= 4'b0000;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            we_r    <= we_s;
            wdata_r <= wdata_s;
            be_r    <= be_s;
        end
    end

    assign bus.mem_req   = active_s;
    assign bus.mem_we    = active_s ? we_r    : 1'b0;
    assign bus.mem_addr  = active_s ? addr_r  : {D_WIDTH{1'b0}};
    assign bus.mem_wdata = active_s ? wdata_r : {D_WIDTH{1'b0}};
    assign bus.mem_be    = active_s ? be_r    : 4'b0000;
    assign bus.grant     = state_r;
    assign bus.bus_err   = abort_s;

    assign bus.if_valid  = done_s && (state_r == IF_ACC);
    assign bus.dm_valid  = done_s && (state_r == DM_ACC);
    assign bus.if_rdata  = bus.if_valid ? bus.mem_rdata : {D_WIDTH{1'b0}};
    assign bus.dm_rdata  = bus.dm_valid ? bus.mem_rdata : {D_WIDTH{1'b0}};
    assign bus.if_stall  = bus.if_req && !bus.if_valid;
    assign bus.dm_stall  = bus.dm_req && !bus.dm_valid;
endmodule
